// File: rtl/spi_flash_pkg.sv
// Shared types for the SPI flash fetch path: response codes, fetch FSM states, default line size.
// Latency: n/a (types only).
// Backpressure: n/a.
package spi_flash_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL_AR,
        ST_FILL_R,
        ST_RESP
    } fetch_state_t;

    localparam int LINE_WORDS_DEF = 4;

endpackage

// File: rtl/fetch_line_store.sv
// One-line buffer: word array, tag and valid bit, plus the combinational hit compare.
// Latency: hit and rd_word are combinational from lookup_addr; writes land on the next clk.
// Backpressure: none; the owner sequences writes and valid updates.
module fetch_line_store
    import spi_flash_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    localparam int OFS_W     = $clog2(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:2] lookup_addr,
    input  logic              tag_wr,
    input  logic              wr_en,
    input  logic [OFS_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic              valid_set,
    input  logic              valid_clr,
    output logic              hit,
    output logic [DATA_W-1:0] rd_word
);

    logic [ADDR_W-OFS_W-3:0] tag_q;
    logic                    valid_q;
    logic [DATA_W-1:0]       data_q [LINE_WORDS];

    // Tag and valid; a clear wins over a set so a flush is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            if (tag_wr)
                tag_q <= lookup_addr[ADDR_W-1:OFS_W+2];
            if (valid_clr)
                valid_q <= 1'b0;
            else if (valid_set)
                valid_q <= 1'b1;
        end
    end

    // Word array needs no reset: it is only read while valid_q is set.
    always_ff @(posedge clk) begin
        if (wr_en)
            data_q[wr_idx] <= wr_dat;
    end

    assign hit     = valid_q && (tag_q == lookup_addr[ADDR_W-1:OFS_W+2]);
    assign rd_word = data_q[lookup_addr[OFS_W+1:2]];

endmodule

// File: rtl/spi_fetch_buffer.sv
// Read-only one-line buffer between the CPU AXI4-lite read channel and the quad-SPI reader.
// Latency: hit 1 cycle to s_rvalid; miss 1 + LINE_WORDS x downstream beat latency.
// Backpressure: s_arready only in IDLE with init_done; response held until s_rready; one read outstanding downstream.
module spi_fetch_buffer
    import spi_flash_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = LINE_WORDS_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              init_done,
    input  logic              flush,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [DATA_W-1:0] s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready,
    output logic              rd_en,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
);

    localparam int OFS_W = $clog2(LINE_WORDS);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [OFS_W-1:0]  beat_q;
    logic [DATA_W-1:0] rdata_q;
    resp_t             rresp_q;
    logic              flush_pend_q;
    logic [15:0]       hit_cnt_q, miss_cnt_q;

    logic              hit, accept, in_fill, resp_done;
    logic              beat_done, beat_err, last_beat;
    logic [DATA_W-1:0] line_word;
    logic              unused_byte_ofs;

    assign unused_byte_ofs = ^s_araddr[1:0];

    assign accept    = s_arready && s_arvalid;
    assign in_fill   = (state_q == ST_FILL_AR) || (state_q == ST_FILL_R);
    assign resp_done = (state_q == ST_RESP) && s_rready;
    assign beat_done = (state_q == ST_FILL_R) && m_rvalid;
    assign beat_err  = (m_rresp != RESP_OKAY);
    assign last_beat = (beat_q == OFS_W'(LINE_WORDS - 1));

    fetch_line_store #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .LINE_WORDS (LINE_WORDS)
    ) u_line (
        .clk         (CLK),
        .rst         (RST),
        .lookup_addr (s_araddr[ADDR_W-1:2]),
        .tag_wr      (accept && !hit),
        .wr_en       (beat_done && !beat_err),
        .wr_idx      (beat_q),
        .wr_dat      (m_rdata),
        .valid_set   (beat_done && !beat_err && last_beat),
        .valid_clr   ((accept && !hit)
                      || (flush && ((state_q == ST_IDLE) || (state_q == ST_RESP)))
                      || (resp_done && flush_pend_q)),
        .hit         (hit),
        .rd_word     (line_word)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RST)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next state and handshake outputs; everything idles at zero.
    always_comb begin
        state_d   = state_q;
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        s_rdata   = '0;
        s_rresp   = RESP_OKAY;
        m_arvalid = 1'b0;
        m_araddr  = '0;
        m_rready  = 1'b0;
        rd_en     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                s_arready = init_done && !RST;
                if (s_arready && s_arvalid)
                    state_d = hit ? ST_RESP : ST_FILL_AR;
            end
            ST_FILL_AR: begin
                rd_en     = 1'b1;
                m_arvalid = 1'b1;
                m_araddr  = {addr_q[ADDR_W-1:OFS_W+2], beat_q, 2'b00};
                if (m_arready)
                    state_d = ST_FILL_R;
            end
            ST_FILL_R: begin
                rd_en    = 1'b1;
                m_rready = 1'b1;
                if (m_rvalid)
                    state_d = (beat_err || last_beat) ? ST_RESP : ST_FILL_AR;
            end
            ST_RESP: begin
                s_rvalid = 1'b1;
                s_rdata  = rdata_q;
                s_rresp  = rresp_q;
                if (s_rready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request address, beat counter, response capture and deferred flush.
    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_q       <= '0;
            beat_q       <= '0;
            rdata_q      <= '0;
            rresp_q      <= RESP_OKAY;
            flush_pend_q <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= s_araddr;
                beat_q  <= '0;
                rresp_q <= RESP_OKAY;
                rdata_q <= hit ? line_word : '0;
            end
            if (beat_done) begin
                if (beat_err) begin
                    rresp_q <= RESP_SLVERR;
                    rdata_q <= '0;
                end else begin
                    if (beat_q == addr_q[OFS_W+1:2])
                        rdata_q <= m_rdata;
                    if (!last_beat)
                        beat_q <= beat_q + 1'b1;
                end
            end
            if (flush && in_fill)
                flush_pend_q <= 1'b1;
            else if (resp_done)
                flush_pend_q <= 1'b0;
        end
    end

    // Saturating hit/miss statistics, counted at request accept.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (accept) begin
            if (hit) begin
                if (hit_cnt_q != 16'hFFFF)
                    hit_cnt_q <= hit_cnt_q + 16'd1;
            end else if (miss_cnt_q != 16'hFFFF) begin
                miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_spi_fetch_buffer.sv
// Directed bench for spi_fetch_buffer with a one-outstanding flash reader model.
// Latency: reader accepts an address one cycle after m_arvalid and returns data the cycle after.
// Backpressure: upstream s_rready driven per test, held low for the stall case.
module tb_spi_fetch_buffer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        init_done = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] s_araddr = '0;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready = 1'b1;
    logic [31:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready = 1'b0;
    logic [31:0] m_rdata = '0;
    logic [1:0]  m_rresp = '0;
    logic        m_rvalid = 1'b0;
    logic        m_rready;
    logic        rd_en;
    logic [15:0] hit_cnt, miss_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    spi_fetch_buffer dut (
        .CLK       (CLK),
        .RST       (RST),
        .init_done (init_done),
        .flush     (flush),
        .s_araddr  (s_araddr),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .m_araddr  (m_araddr),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .rd_en     (rd_en),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    always #5 CLK = ~CLK;

    // Flash contents: high half is the low address half XOR 5A5A, low half is the address.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reader model: handshakes observed on posedge, responses driven on negedge.
    logic [31:0] fetched[$];
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    logic [31:0] ar_addr_s, paddr;
    bit          ar_hs = 0, r_hs = 0, pend = 0;

    always @(posedge CLK) begin
        ar_hs     = m_arvalid & m_arready;
        r_hs      = m_rvalid & m_rready;
        ar_addr_s = m_araddr;
    end

    always @(negedge CLK) begin
        if (RST) begin
            m_arready = 1'b0;
            m_rvalid  = 1'b0;
            m_rresp   = 2'b00;
            m_rdata   = '0;
            pend      = 0;
        end else begin
            if (r_hs)
                m_rvalid = 1'b0;
            if (ar_hs) begin
                m_arready = 1'b0;
                pend      = 1;
                paddr     = ar_addr_s;
                fetched.push_back(ar_addr_s);
            end
            if (pend && !m_rvalid) begin
                m_rvalid = 1'b1;
                m_rdata  = mem(paddr);
                m_rresp  = (paddr == err_addr) ? 2'b10 : 2'b00;
                if (paddr == err_addr)
                    err_addr = 32'hFFFF_FFFF;
                pend = 0;
            end
            if (m_arvalid && !m_arready && !pend && !m_rvalid)
                m_arready = 1'b1;
        end
    end

    // One upstream read; lat counts cycles from accept edge to first s_rvalid sample.
    task automatic rd(input logic [31:0] a, input int stall,
                      output logic [31:0] d, output logic [1:0] r, output int lat);
        int  n;
        bit  ok;
        d   = '0;
        r   = '0;
        lat = -1;
        fetched.delete();
        @(negedge CLK);
        s_araddr  = a;
        s_arvalid = 1'b1;
        s_rready  = (stall == 0);
        n = 0;
        while (!s_arready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (!s_arready) begin
            chk("ar_timeout", 32'd0, 32'd1);
            s_arvalid = 1'b0;
            return;
        end
        @(posedge CLK);
        @(negedge CLK);
        s_arvalid = 1'b0;
        lat = 1;
        while (!s_rvalid && lat < 200) begin
            @(negedge CLK);
            lat++;
        end
        if (!s_rvalid) begin
            chk("r_timeout", 32'd0, 32'd1);
            s_rready = 1'b1;
            return;
        end
        d = s_rdata;
        r = s_rresp;
        if (stall > 0) begin
            ok = 1;
            for (int k = 0; k < stall; k++) begin
                @(negedge CLK);
                if (!s_rvalid || s_rdata !== d || s_rresp !== r)
                    ok = 0;
            end
            chk("stall_stable", {31'd0, ok}, 32'd1);
            s_rready = 1'b1;
        end
        @(negedge CLK);
        chk("rvalid_drop", {31'd0, s_rvalid}, 32'd0);
    endtask

    task automatic chk_fill(input string tag, input logic [31:0] base);
        chk({tag, "_nbeats"}, fetched.size(), 32'd4);
        for (int k = 0; k < 4; k++)
            if (k < fetched.size())
                chk({tag, "_addr"}, fetched[k], base + 32'(4 * k));
    endtask

    logic [31:0] d;
    logic [1:0]  r;
    int          lat;

    initial begin
        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_arready", {31'd0, s_arready}, 32'd0);
        chk("rst_rvalid",  {31'd0, s_rvalid},  32'd0);
        chk("rst_arvalid", {31'd0, m_arvalid}, 32'd0);
        chk("rst_rd_en",   {31'd0, rd_en},     32'd0);
        chk("rst_hits",    {16'd0, hit_cnt},   32'd0);
        chk("rst_misses",  {16'd0, miss_cnt},  32'd0);
        RST = 1'b0;

        // Held off until init completes
        @(negedge CLK);
        s_araddr  = 32'h100;
        s_arvalid = 1'b1;
        repeat (3) @(negedge CLK);
        chk("preinit_arready", {31'd0, s_arready}, 32'd0);
        chk("preinit_arvalid", {31'd0, m_arvalid}, 32'd0);
        s_arvalid = 1'b0;
        init_done = 1'b1;

        // First miss fills 0x100..0x10C
        rd(32'h100, 0, d, r, lat);
        chk("miss1_data", d, 32'h5B5A_0100);
        chk("miss1_resp", {30'd0, r}, 32'd0);
        chk("miss1_lat", lat, 32'd9);
        chk_fill("miss1", 32'h100);

        // Hit in the same line
        rd(32'h104, 0, d, r, lat);
        chk("hit_data", d, 32'h5B5E_0104);
        chk("hit_lat", lat, 32'd1);
        chk("hit_no_fetch", fetched.size(), 32'd0);

        // Miss to another line
        rd(32'h204, 0, d, r, lat);
        chk("miss2_data", d, 32'h585E_0204);
        chk_fill("miss2", 32'h200);
        chk("cnt_miss2", {16'd0, miss_cnt}, 32'd2);
        chk("cnt_hit1",  {16'd0, hit_cnt},  32'd1);

        // Flush in IDLE, then a fill whose last beat errors
        @(negedge CLK);
        flush = 1'b1;
        @(negedge CLK);
        flush    = 1'b0;
        err_addr = 32'h20C;
        rd(32'h200, 0, d, r, lat);
        chk("err_resp", {30'd0, r}, 32'd2);
        chk("err_data", d, 32'd0);
        chk_fill("err", 32'h200);
        rd(32'h200, 0, d, r, lat);
        chk("refetch_data", d, 32'h585A_0200);
        chk("refetch_resp", {30'd0, r}, 32'd0);
        chk_fill("refetch", 32'h200);

        // Flush during a fill: data still served, line invalid afterwards
        fork
            rd(32'h400, 0, d, r, lat);
            begin
                repeat (4) @(negedge CLK);
                flush = 1'b1;
                @(negedge CLK);
                flush = 1'b0;
            end
        join
        chk("flushfill_data", d, 32'h5E5A_0400);
        chk("flushfill_lat", lat, 32'd9);
        rd(32'h408, 0, d, r, lat);
        chk("postflush_lat", lat, 32'd9);
        chk("postflush_data", d, 32'h5E52_0408);
        chk_fill("postflush", 32'h400);

        // Upstream stall on a hit
        rd(32'h40C, 10, d, r, lat);
        chk("stall_data", d, 32'h5E56_040C);
        chk("stall_lat", lat, 32'd1);
        chk("cnt_hit2",  {16'd0, hit_cnt},  32'd2);
        chk("cnt_miss6", {16'd0, miss_cnt}, 32'd6);

        // Reset in the middle of FILL_R
        @(negedge CLK);
        s_araddr  = 32'h500;
        s_arvalid = 1'b1;
        @(negedge CLK);
        s_arvalid = 1'b0;
        for (int n = 0; n < 50 && !m_rready; n++)
            @(negedge CLK);
        chk("reach_fill_r", {31'd0, m_rready}, 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        chk("mrst_rvalid",  {31'd0, s_rvalid},  32'd0);
        chk("mrst_arready", {31'd0, s_arready}, 32'd0);
        chk("mrst_arvalid", {31'd0, m_arvalid}, 32'd0);
        chk("mrst_rready",  {31'd0, m_rready},  32'd0);
        chk("mrst_rd_en",   {31'd0, rd_en},     32'd0);
        chk("mrst_araddr",  m_araddr,           32'd0);
        chk("mrst_rdata",   s_rdata,            32'd0);
        chk("mrst_hits",    {16'd0, hit_cnt},   32'd0);
        chk("mrst_misses",  {16'd0, miss_cnt},  32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Previously buffered line is gone
        rd(32'h104, 0, d, r, lat);
        chk("postrst_lat", lat, 32'd9);
        chk("postrst_data", d, 32'h5B5E_0104);
        chk_fill("postrst", 32'h100);
        chk("postrst_misses", {16'd0, miss_cnt}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
